// File: rtl/axis_capture_ctrl.sv
// Measurement-window controller for a pass-through AXI-Stream debug tap.
// It gates the stream open in RUN/DRAIN and counts beats, packets, stalls and window cycles.
module axis_capture_ctrl #(
  parameter int C_AXIS_BYTEWIDTH = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cmd_start,
  input  logic                            cmd_stop,
  input  logic [31:0]                     cfg_pkt_limit,
  input  logic [31:0]                     cfg_timeout,
  input  logic                            input_s_axis_tvalid,
  input  logic [8*C_AXIS_BYTEWIDTH-1:0]   input_s_axis_tdata,
  input  logic [C_AXIS_BYTEWIDTH-1:0]     input_s_axis_tstrb,
  input  logic                            input_s_axis_tlast,
  output logic                            input_s_axis_tready,
  output logic                            output_m_axis_tvalid,
  output logic [8*C_AXIS_BYTEWIDTH-1:0]   output_m_axis_tdata,
  output logic [C_AXIS_BYTEWIDTH-1:0]     output_m_axis_tstrb,
  output logic                            output_m_axis_tlast,
  input  logic                            output_m_axis_tready,
  output logic [1:0]                      state,
  output logic                            done,
  output logic                            timed_out,
  output logic [31:0]                     beat_count,
  output logic [31:0]                     pkt_count,
  output logic [31:0]                     stall_count,
  output logic [31:0]                     cycle_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        in_pkt_q, in_pkt_d;
  logic        done_q, done_d;
  logic        timed_out_q, timed_out_d;
  logic [31:0] beat_q, beat_d, pkt_q, pkt_d, stall_q, stall_d, cycle_q, cycle_d;
  logic [31:0] limit_q, limit_d, timeout_q, timeout_d;

  logic gate, hs, hs_last, stall, limit_hit, tmo_hit;

  // The gate depends on the state register only, so commands never reach the stream combinationally.
  assign gate    = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign hs      = input_s_axis_tvalid && output_m_axis_tready && gate;
  assign hs_last = hs && input_s_axis_tlast;
  assign stall   = gate && input_s_axis_tvalid && !output_m_axis_tready;

  assign input_s_axis_tready  = output_m_axis_tready && gate;
  assign output_m_axis_tvalid = input_s_axis_tvalid && gate;
  assign output_m_axis_tdata  = input_s_axis_tdata;
  assign output_m_axis_tstrb  = input_s_axis_tstrb;
  assign output_m_axis_tlast  = input_s_axis_tlast;

  assign limit_hit = hs_last && (limit_q != '0) && (pkt_q + 32'd1 == limit_q);
  assign tmo_hit   = (timeout_q != '0) && (cycle_q + 32'd1 == timeout_q);

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != '1)) ? v + 32'd1 : v;
  endfunction

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    in_pkt_d    = in_pkt_q;
    timed_out_d = timed_out_q;
    limit_d     = limit_q;
    timeout_d   = timeout_q;
    beat_d      = sat_inc(beat_q, hs);
    pkt_d       = sat_inc(pkt_q, hs_last);
    stall_d     = sat_inc(stall_q, stall);
    cycle_d     = sat_inc(cycle_q, gate);
    if (hs) in_pkt_d = !input_s_axis_tlast;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (cmd_start) begin
          state_d     = S_RUN;
          in_pkt_d    = 1'b0;
          timed_out_d = 1'b0;
          limit_d     = cfg_pkt_limit;
          timeout_d   = cfg_timeout;
          beat_d      = '0;
          pkt_d       = '0;
          stall_d     = '0;
          cycle_d     = '0;
        end
      end
      S_RUN: begin
        if (limit_hit) begin
          state_d = S_DONE;
        end else if (cmd_stop || tmo_hit) begin
          if (tmo_hit) timed_out_d = 1'b1;
          // Close right away only at a packet boundary; otherwise finish the open packet.
          state_d = (hs_last || (!in_pkt_q && !hs)) ? S_DONE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (hs_last) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    done_d = (state_d == S_DONE) && (state_q != S_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      in_pkt_q    <= 1'b0;
      done_q      <= 1'b0;
      timed_out_q <= 1'b0;
      beat_q      <= '0;
      pkt_q       <= '0;
      stall_q     <= '0;
      cycle_q     <= '0;
      limit_q     <= '0;
      timeout_q   <= '0;
    end else begin
      state_q     <= state_d;
      in_pkt_q    <= in_pkt_d;
      done_q      <= done_d;
      timed_out_q <= timed_out_d;
      beat_q      <= beat_d;
      pkt_q       <= pkt_d;
      stall_q     <= stall_d;
      cycle_q     <= cycle_d;
      limit_q     <= limit_d;
      timeout_q   <= timeout_d;
    end
  end

  assign state       = state_q;
  assign done        = done_q;
  assign timed_out   = timed_out_q;
  assign beat_count  = beat_q;
  assign pkt_count   = pkt_q;
  assign stall_count = stall_q;
  assign cycle_count = cycle_q;

endmodule
